// File: rtl/agc_quantize.sv
`default_nettype none
// ============================================================================
// Module   : agc_quantize
// Brief    : 2-bit offset-binary sample quantizer with windowed automatic
//            gain control of the magnitude threshold.
// Revision : 1.0 - initial release
// ============================================================================
module agc_quantize #(
   parameter int W        = 8,
   parameter int LOG_WIN  = 10,
   parameter int THR_INIT = 8,
   parameter int THR_MIN  = 1,
   parameter int THR_MAX  = (1 << (W - 1)) - 1,
   parameter int TGT_LO   = 307,
   parameter int TGT_HI   = 348
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               x_valid,
   input  logic [W-1:0]       x,
   input  logic               agc_en,
   input  logic               thr_load,
   input  logic [W-2:0]       thr_value,
   output logic               y_valid,
   output logic [1:0]         y,
   output logic [W-2:0]       thr,
   output logic               win_done,
   output logic [LOG_WIN:0]   win_count
);

   localparam logic [W-2:0]     c_thr_init = THR_INIT[W-2:0];
   localparam logic [W-2:0]     c_thr_min  = THR_MIN[W-2:0];
   localparam logic [W-2:0]     c_thr_max  = THR_MAX[W-2:0];
   localparam logic [W-2:0]     c_thr_one  = {{(W-2){1'b0}}, 1'b1};
   localparam logic [LOG_WIN:0] c_tgt_lo   = TGT_LO[LOG_WIN:0];
   localparam logic [LOG_WIN:0] c_tgt_hi   = TGT_HI[LOG_WIN:0];
   localparam logic [LOG_WIN-1:0] c_wcnt_one = {{(LOG_WIN-1){1'b0}}, 1'b1};

   logic [LOG_WIN-1:0] r_wcnt;
   logic [LOG_WIN:0]   r_lcnt;

   logic [W-2:0]       w_mag;
   logic               w_large;
   logic               w_win_end;
   logic [LOG_WIN:0]   w_final;
   logic [W-2:0]       w_thr_nxt;

   // One's-complement magnitude: the most negative code maps to the top
   // magnitude instead of overflowing.
   assign w_mag     = x[W-1] ? ~x[W-2:0] : x[W-2:0];
   assign w_large   = (w_mag >= thr);
   assign w_win_end = x_valid && (r_wcnt == {LOG_WIN{1'b1}});
   assign w_final   = r_lcnt + {{LOG_WIN{1'b0}}, w_large};

   always_comb begin
      w_thr_nxt = thr;
      if (thr_load) begin
         w_thr_nxt = thr_value;
      end else if (w_win_end && agc_en) begin
         if ((w_final > c_tgt_hi) && (thr < c_thr_max)) begin
            w_thr_nxt = thr + c_thr_one;
         end else if ((w_final < c_tgt_lo) && (thr > c_thr_min)) begin
            w_thr_nxt = thr - c_thr_one;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y         <= 2'b00;
         y_valid   <= 1'b0;
         win_done  <= 1'b0;
         win_count <= '0;
         thr       <= c_thr_init;
         r_wcnt    <= '0;
         r_lcnt    <= '0;
      end else begin
         y_valid  <= x_valid;
         win_done <= w_win_end;
         thr      <= w_thr_nxt;
         if (x_valid) begin
            y      <= {~x[W-1], x[W-1] ^ w_large};
            r_wcnt <= r_wcnt + c_wcnt_one;
            if (w_win_end) begin
               win_count <= w_final;
               r_lcnt    <= '0;
            end else begin
               r_lcnt    <= w_final;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_agc_quantize.sv
`default_nettype none
// ============================================================================
// Module   : tb_agc_quantize
// Brief    : Directed self-checking bench for agc_quantize (LOG_WIN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_agc_quantize;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       x_valid;
   logic [7:0] x;
   logic       agc_en;
   logic       thr_load;
   logic [6:0] thr_value;
   logic       y_valid;
   logic [1:0] y;
   logic [6:0] thr;
   logic       win_done;
   logic [4:0] win_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   agc_quantize #(
      .W(8), .LOG_WIN(4), .THR_INIT(8), .THR_MIN(1), .THR_MAX(63),
      .TGT_LO(4), .TGT_HI(6)
   ) dut (
      .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x),
      .agc_en(agc_en), .thr_load(thr_load), .thr_value(thr_value),
      .y_valid(y_valid), .y(y), .thr(thr), .win_done(win_done),
      .win_count(win_count)
   );

   // Present one cycle of input, then sample outputs 1 ns after the edge.
   task automatic step(input logic v, input logic [7:0] xv);
      x_valid = v;
      x       = xv;
      @(posedge clk);
      #1;
      x_valid  = 1'b0;
      thr_load = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [1:0] exp_y [8] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
      logic [7:0] vec   [8] = '{8'h00, 8'h07, 8'h08, 8'h7F, 8'hFF, 8'hF8, 8'hF7, 8'h80};
      do_reset();
      thr_value = 7'd30;
      thr_load  = 1'b1;
      step(1'b0, 8'h00);
      repeat (5) step(1'b1, 8'h40);
      x_valid = 1'b1;
      x       = 8'h40;
      #3;
      rst_n = 1'b0;
      #1;
      total++; if (y !== 2'b00) begin bad++; $display("FAIL reset_y got=%b exp=00", y); end
      total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_yvalid got=%b exp=0", y_valid); end
      total++; if (thr !== 7'd8) begin bad++; $display("FAIL reset_thr got=%0d exp=8", thr); end
      total++; if (win_count !== 5'd0) begin bad++; $display("FAIL reset_wincount got=%0d exp=0", win_count); end
      total++; if (win_done !== 1'b0) begin bad++; $display("FAIL reset_windone got=%b exp=0", win_done); end
      x_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, vec[i]);
         total++;
         if (y !== exp_y[i] || y_valid !== 1'b1) begin
            bad++; $display("FAIL slice x=%h got y=%b v=%b exp y=%b v=1", vec[i], y, y_valid, exp_y[i]);
         end
      end
      step(1'b0, 8'h00);
      total++; if (y !== 2'b00 || y_valid !== 1'b0) begin bad++; $display("FAIL hold got y=%b v=%b exp y=00 v=0", y, y_valid); end
   endtask

   task automatic test_agc_up();
      int exp_thr;
      do_reset();
      agc_en = 1'b1;
      for (int w = 0; w < 56; w++) begin
         for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'h40);
            if (i < 15) begin
               total++; if (win_done !== 1'b0) begin bad++; $display("FAIL up_early_done w=%0d i=%0d got=1 exp=0", w, i); end
            end
         end
         exp_thr = (9 + w > 63) ? 63 : 9 + w;
         total++; if (win_done !== 1'b1) begin bad++; $display("FAIL up_done w=%0d got=%b exp=1", w, win_done); end
         total++; if (win_count !== 5'd16) begin bad++; $display("FAIL up_count w=%0d got=%0d exp=16", w, win_count); end
         total++; if (thr !== exp_thr[6:0]) begin bad++; $display("FAIL up_thr w=%0d got=%0d exp=%0d", w, thr, exp_thr); end
         if (w == 0) begin
            step(1'b0, 8'h00);
            total++; if (win_done !== 1'b0) begin bad++; $display("FAIL up_pulse got=%b exp=0", win_done); end
         end
      end
   endtask

   task automatic test_agc_down();
      int exp_thr;
      do_reset();
      agc_en = 1'b1;
      repeat (16) step(1'b1, 8'h01);
      total++; if (win_count !== 5'd0) begin bad++; $display("FAIL down_count got=%0d exp=0", win_count); end
      total++; if (thr !== 7'd7) begin bad++; $display("FAIL down_thr got=%0d exp=7", thr); end
      for (int w = 1; w <= 8; w++) begin
         repeat (16) step(1'b1, 8'h00);
         exp_thr = (7 - w < 1) ? 1 : 7 - w;
         total++; if (thr !== exp_thr[6:0]) begin bad++; $display("FAIL down_thr w=%0d got=%0d exp=%0d", w, thr, exp_thr); end
      end
   endtask

   task automatic test_deadband();
      int nl   [5] = '{4, 5, 6, 7, 3};
      int ethr [5] = '{8, 8, 8, 9, 8};
      do_reset();
      agc_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 16; i++) step(1'b1, (i < nl[k]) ? 8'hC0 : 8'h02);
         total++; if (win_count !== nl[k][4:0]) begin bad++; $display("FAIL band_count n=%0d got=%0d exp=%0d", nl[k], win_count, nl[k]); end
         total++; if (thr !== ethr[k][6:0]) begin bad++; $display("FAIL band_thr n=%0d got=%0d exp=%0d", nl[k], thr, ethr[k]); end
      end
      agc_en = 1'b0;
      repeat (16) step(1'b1, 8'h40);
      total++; if (win_count !== 5'd16 || win_done !== 1'b1) begin bad++; $display("FAIL freeze_count got=%0d done=%b exp=16 done=1", win_count, win_done); end
      total++; if (thr !== 7'd8) begin bad++; $display("FAIL freeze_thr got=%0d exp=8", thr); end
      repeat (16) step(1'b1, 8'h00);
      total++; if (win_count !== 5'd0 || thr !== 7'd8) begin bad++; $display("FAIL freeze_low got count=%0d thr=%0d exp 0 8", win_count, thr); end
   endtask

   task automatic test_priority();
      do_reset();
      agc_en = 1'b1;
      repeat (15) step(1'b1, 8'h40);
      thr_value = 7'd20;
      thr_load  = 1'b1;
      step(1'b1, 8'h40);
      total++; if (thr !== 7'd20) begin bad++; $display("FAIL prio_thr got=%0d exp=20", thr); end
      total++; if (win_count !== 5'd16 || win_done !== 1'b1) begin bad++; $display("FAIL prio_count got=%0d done=%b exp=16 done=1", win_count, win_done); end
      thr_value = 7'd100;
      thr_load  = 1'b1;
      step(1'b1, 8'h40);
      total++; if (y !== 2'b11) begin bad++; $display("FAIL load_oldthr got=%b exp=11", y); end
      step(1'b1, 8'h40);
      total++; if (y !== 2'b10 || thr !== 7'd100) begin bad++; $display("FAIL load_newthr got y=%b thr=%0d exp 10 100", y, thr); end
      thr_value = 7'd0;
      thr_load  = 1'b1;
      step(1'b0, 8'h00);
      step(1'b1, 8'h00);
      total++; if (y !== 2'b11) begin bad++; $display("FAIL zero_pos got=%b exp=11", y); end
      step(1'b1, 8'hFF);
      total++; if (y !== 2'b00) begin bad++; $display("FAIL zero_neg got=%b exp=00", y); end
   endtask

   task automatic test_gaps();
      int         nvalid = 0;
      int         nlarge = 0;
      int         iter   = 0;
      logic       v;
      logic [7:0] xv;
      logic [6:0] mag;
      logic       lg;
      logic [1:0] exp_y = 2'b00;
      do_reset();
      agc_en = 1'b0;
      while (nvalid < 16 && iter < 400) begin
         iter++;
         v  = ($urandom_range(0, 2) == 0);
         xv = 8'($urandom);
         if (v) begin
            nvalid++;
            mag = xv[7] ? ~xv[6:0] : xv[6:0];
            lg  = (mag >= 7'd8);
            if (lg) nlarge++;
            exp_y = {~xv[7], xv[7] ^ lg};
         end
         step(v, xv);
         total++; if (y_valid !== v) begin bad++; $display("FAIL gap_yvalid it=%0d got=%b exp=%b", iter, y_valid, v); end
         total++; if (y !== exp_y) begin bad++; $display("FAIL gap_y it=%0d got=%b exp=%b", iter, y, exp_y); end
         total++; if (win_done !== (v && nvalid == 16)) begin bad++; $display("FAIL gap_done it=%0d n=%0d got=%b", iter, nvalid, win_done); end
      end
      total++; if (nvalid != 16) begin bad++; $display("FAIL gap_budget got=%0d exp=16", nvalid); end
      total++; if (win_count !== nlarge[4:0]) begin bad++; $display("FAIL gap_count got=%0d exp=%0d", win_count, nlarge); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      x_valid   = 1'b0;
      x         = 8'h00;
      agc_en    = 1'b0;
      thr_load  = 1'b0;
      thr_value = 7'd0;
      test_reset();
      test_agc_up();
      test_agc_down();
      test_deadband();
      test_priority();
      test_gaps();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
